// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, mul/div EX occupancy FSM, taken-branch flush.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cycles / flush_count counters.
//
//   state   | meaning
//   IDLE    | no mul/div in flight; start accepted here
//   BUSY    | mul/div holding EX, pipeline stalled, cnt counting down
//   RELEASE | final mul/div cycle, pipeline runs, start ignored
module hazard_stall_ctrl #(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        uses_rt_id,
    input  logic [4:0]  rt_ex,
    input  logic        MemRead_ex,
    input  logic        muldiv_start_ex,
    input  logic        branch_taken_ex,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        muldiv_go,
    output logic        muldiv_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_BUSY    = 2'b01;
    localparam logic [1:0] ST_RELEASE = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic start_req;
    logic md_stall;
    logic load_use;

    assign start_req = (state_q == ST_IDLE) && muldiv_start_ex && !branch_taken_ex;
    assign md_stall  = start_req || (state_q == ST_BUSY);

    assign load_use = MemRead_ex && (rt_ex != 5'd0) &&
                      ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));

    // Priority: mul/div stall, then branch flush (ID is wrong-path), then load-use.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        muldiv_go   = 1'b0;
        if (md_stall) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            exmem_flush = 1'b1;
            muldiv_go   = start_req;
        end else if (branch_taken_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign muldiv_busy = (state_q == ST_BUSY) || (state_q == ST_RELEASE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    if (MULDIV_CYCLES == 2) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                // A zero count is unreachable; treat it as done rather than wrap.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!pc_we && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (ifid_flush && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: MULDIV_CYCLES=4 and =2 instances side by side.
// Perf-counter scenario runs only when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_id, rt_id, rt_ex;
    logic       uses_rt_id, MemRead_ex, muldiv_start_ex, muldiv_start_2, branch_taken_ex;

    logic pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, muldiv_go, muldiv_busy;
    logic pc_we2, ifid_we2, ifid_flush2, idex_flush2, exmem_flush2, muldiv_go2, muldiv_busy2;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles, flush_count, stall_cycles2, flush_count2;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, muldiv_go, muldiv_busy}
    logic [6:0] ctl, ctl2;
    assign ctl  = {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, muldiv_go, muldiv_busy};
    assign ctl2 = {pc_we2, ifid_we2, ifid_flush2, idex_flush2, exmem_flush2, muldiv_go2, muldiv_busy2};

    localparam logic [6:0] C_IDLE    = 7'b1100000;
    localparam logic [6:0] C_LU      = 7'b0001000;
    localparam logic [6:0] C_BR      = 7'b1111000;
    localparam logic [6:0] C_START   = 7'b0000110;
    localparam logic [6:0] C_BUSY    = 7'b0000101;
    localparam logic [6:0] C_RELEASE = 7'b1100001;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MULDIV_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
        .rt_ex(rt_ex), .MemRead_ex(MemRead_ex), .muldiv_start_ex(muldiv_start_ex),
        .branch_taken_ex(branch_taken_ex), .pc_we(pc_we), .ifid_we(ifid_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .muldiv_go(muldiv_go), .muldiv_busy(muldiv_busy)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    hazard_stall_ctrl #(.MULDIV_CYCLES(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
        .rt_ex(rt_ex), .MemRead_ex(MemRead_ex), .muldiv_start_ex(muldiv_start_2),
        .branch_taken_ex(branch_taken_ex), .pc_we(pc_we2), .ifid_we(ifid_we2),
        .ifid_flush(ifid_flush2), .idex_flush(idex_flush2), .exmem_flush(exmem_flush2),
        .muldiv_go(muldiv_go2), .muldiv_busy(muldiv_busy2)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles2), .flush_count(flush_count2)
`endif
    );

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_id = 5'd0; rt_id = 5'd0; rt_ex = 5'd0; uses_rt_id = 1'b0;
        MemRead_ex = 1'b0; muldiv_start_ex = 1'b0; muldiv_start_2 = 1'b0;
        branch_taken_ex = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #12;
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++; $display("FAIL reset_m4: got %b want %b", ctl, C_IDLE);
        end
        vectors++;
        if (ctl2 !== C_IDLE) begin
            miscompares++; $display("FAIL reset_m2: got %b want %b", ctl2, C_IDLE);
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_load_use();
        MemRead_ex = 1'b1; rt_ex = 5'd5; rs_id = 5'd5;
        @(negedge clk);
        vectors++;
        if (ctl !== C_LU) begin
            miscompares++; $display("FAIL lu_rs: got %b want %b", ctl, C_LU);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++; $display("FAIL lu_one_cycle: got %b want %b", ctl, C_IDLE);
        end
        next_cycle();
        MemRead_ex = 1'b1; rt_ex = 5'd0; rs_id = 5'd0;
        @(negedge clk);
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++; $display("FAIL lu_r0: got %b want %b", ctl, C_IDLE);
        end
        next_cycle();
        MemRead_ex = 1'b1; rt_ex = 5'd5; rs_id = 5'd3; rt_id = 5'd5; uses_rt_id = 1'b0;
        @(negedge clk);
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++; $display("FAIL lu_rt_unused: got %b want %b", ctl, C_IDLE);
        end
        next_cycle();
        uses_rt_id = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl !== C_LU) begin
            miscompares++; $display("FAIL lu_rt_used: got %b want %b", ctl, C_LU);
        end
        next_cycle();
        MemRead_ex = 1'b0;
        @(negedge clk);
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++; $display("FAIL lu_not_load: got %b want %b", ctl, C_IDLE);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_muldiv4();
        logic [6:0] exp_seq [4];
        exp_seq[0] = C_START; exp_seq[1] = C_BUSY; exp_seq[2] = C_BUSY; exp_seq[3] = C_RELEASE;
        muldiv_start_ex = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (ctl !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL md4_cycle%0d: got %b want %b", i, ctl, exp_seq[i]);
            end
            next_cycle();
        end
        muldiv_start_ex = 1'b0;
        @(negedge clk);
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++; $display("FAIL md4_done: got %b want %b", ctl, C_IDLE);
        end
        next_cycle();
    endtask

    task automatic test_muldiv2();
        muldiv_start_2 = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl2 !== C_START) begin
            miscompares++; $display("FAIL md2_start: got %b want %b", ctl2, C_START);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (ctl2 !== C_RELEASE) begin
            miscompares++; $display("FAIL md2_release: got %b want %b", ctl2, C_RELEASE);
        end
        next_cycle();
        muldiv_start_2 = 1'b0;
        @(negedge clk);
        vectors++;
        if (ctl2 !== C_IDLE) begin
            miscompares++; $display("FAIL md2_done: got %b want %b", ctl2, C_IDLE);
        end
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++; $display("FAIL md2_other_idle: got %b want %b", ctl, C_IDLE);
        end
        next_cycle();
    endtask

    task automatic test_priority();
        branch_taken_ex = 1'b1; MemRead_ex = 1'b1; rt_ex = 5'd7; rs_id = 5'd7;
        @(negedge clk);
        vectors++;
        if (ctl !== C_BR) begin
            miscompares++; $display("FAIL br_over_lu: got %b want %b", ctl, C_BR);
        end
        next_cycle();
        clear_inputs();
        branch_taken_ex = 1'b1; muldiv_start_ex = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl !== C_BR) begin
            miscompares++; $display("FAIL br_over_start: got %b want %b", ctl, C_BR);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++; $display("FAIL br_start_no_fsm: got %b want %b", ctl, C_IDLE);
        end
        next_cycle();
        muldiv_start_ex = 1'b1;
        next_cycle();
        branch_taken_ex = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl !== C_BUSY) begin
            miscompares++; $display("FAIL stall_over_br: got %b want %b", ctl, C_BUSY);
        end
        next_cycle();
        branch_taken_ex = 1'b0;
        next_cycle();
        branch_taken_ex = 1'b1;
        @(negedge clk);
        vectors++;
        if (ctl !== 7'b1111001) begin
            miscompares++; $display("FAIL br_in_release: got %b want %b", ctl, 7'b1111001);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++; $display("FAIL prio_done: got %b want %b", ctl, C_IDLE);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_busy();
        muldiv_start_ex = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        vectors++;
        if (ctl !== C_BUSY) begin
            miscompares++; $display("FAIL rmb_busy2: got %b want %b", ctl, C_BUSY);
        end
        muldiv_start_ex = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ctl !== C_IDLE) begin
            miscompares++; $display("FAIL rmb_async: got %b want %b", ctl, C_IDLE);
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        muldiv_start_ex = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (ctl !== ((i == 0) ? C_START : (i == 3) ? C_RELEASE : C_BUSY)) begin
                miscompares++;
                $display("FAIL rmb_restart%0d: got %b want %b", i, ctl,
                         ((i == 0) ? C_START : (i == 3) ? C_RELEASE : C_BUSY));
            end
            next_cycle();
        end
        clear_inputs();
        next_cycle();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_counters();
        rst_n = 1'b0;
        clear_inputs();
        next_cycle();
        rst_n = 1'b1;
        MemRead_ex = 1'b1; rt_ex = 5'd9; rs_id = 5'd9;
        next_cycle();
        clear_inputs();
        muldiv_start_ex = 1'b1;
        repeat (4) next_cycle();
        muldiv_start_ex = 1'b0;
        branch_taken_ex = 1'b1;
        next_cycle();
        branch_taken_ex = 1'b0;
        @(negedge clk);
        vectors++;
        if (stall_cycles !== 16'd4) begin
            miscompares++; $display("FAIL perf_stall: got %0d want 4", stall_cycles);
        end
        vectors++;
        if (flush_count !== 16'd1) begin
            miscompares++; $display("FAIL perf_flush: got %0d want 1", flush_count);
        end
        next_cycle();
        MemRead_ex = 1'b1; rt_ex = 5'd9; rs_id = 5'd9;
        repeat (65540) @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (stall_cycles !== 16'hFFFF) begin
            miscompares++; $display("FAIL perf_sat: got %h want ffff", stall_cycles);
        end
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_muldiv4();
        test_muldiv2();
        test_priority();
        test_reset_mid_busy();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
